updown_sweep_ctrl: RTL and testbench
====================================

Name: updown_sweep_ctrl

Overview:
Programmable sequencer for a WIDTH-bit up/down count datapath.
- Accepts a configuration over a valid/ready handshake: lower/upper bound, sweep mode, dwell time.
- Then steps the count between the bounds under start/pause/stop control.
- Sits between the control/register side and any display or PWM logic that consumes the count value and direction.

Parameters:
WIDTH, 4, count and bound width
DWELL_W, 8, width of dwell counter (cycles per step minus one)

Ports:
Clk  input  1  clock, rising edge
RST  input  1  synchronous, active-low reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted (high only in IDLE)
cfg_lo  input  WIDTH  lower bound
cfg_hi  input  WIDTH  upper bound
cfg_mode  input  2  00 up-wrap, 01 down-wrap, 10 bounce starting up, 11 bounce starting down
cfg_dwell  input  DWELL_W  count advances every cfg_dwell+1 cycles
cfg_err  output  1  one-cycle pulse: config rejected (cfg_lo > cfg_hi)
start  input  1  begin/resume sweeping
pause  input  1  level; freeze count and dwell timer while high
stop  input  1  abort to IDLE, count held
count  output  WIDTH  current count value
dir  output  1  0 = up, 1 = down
busy  output  1  high in ARMED, RUN, HOLD
bound_hit  output  1  one-cycle pulse on the step that lands on lo or hi

Behaviour:
- Reset: RST sampled low at Clk edge.
  - State -> IDLE.
  - count=0, dir=0, cfg_err=0, bound_hit=0, busy=0, cfg_ready=1.
  - Stored lo=0, hi=2^WIDTH-1, mode=00, dwell=0.
  - Reset mid-sweep abandons all state the same way.
- IDLE:
  - cfg_ready=1.
  - cfg_valid & cfg_lo<=cfg_hi -> store config; count<=lo (modes 00/10) or hi (modes 01/11); dir<=mode[0]; -> ARMED.
  - cfg_valid & cfg_lo>cfg_hi -> cfg_err pulse next cycle; config, count and dir unchanged; stay IDLE.
  - start in IDLE without prior config is ignored.
- ARMED:
  - cfg_ready=0.
  - start -> RUN with dwell timer cleared.
  - stop -> IDLE.
- RUN:
  - Dwell timer increments each cycle. When timer==dwell: timer<=0 and the count takes one step.
  - First step occurs dwell+1 cycles after entering RUN.
- Step rules (all arithmetic modulo 2^WIDTH, never outside [lo,hi]):
  - Mode 00: count==hi -> count<=lo, else count+1.
  - Mode 01: count==lo -> count<=hi, else count-1.
  - Bounce, dir=0: count==hi -> dir<=1, count<=hi-1. The turn and the step happen in the same step; no repeated value.
  - Bounce, dir=1: count==lo -> dir<=0, count<=lo+1.
  - Bounce with lo==hi: count constant, dir toggles each step.
  - bound_hit pulses for one cycle on the step whose new count equals lo or hi.
- HOLD:
  - Entered from RUN when pause=1. Count, dir and dwell timer frozen.
  - pause=0 -> back to RUN; timer resumes from its frozen value.
- Priority when inputs are simultaneous: stop > pause > start.
  - stop in ARMED, RUN or HOLD -> IDLE next cycle. count and dir hold their last values; no step is taken on that edge.
  - start while already in RUN or HOLD is ignored.
- cfg_valid outside IDLE is ignored (cfg_ready=0); no cfg_err.
- All outputs are registered; count changes exactly on the step edge.

Optional Feature:
UPDOWN_SWEEP_LIMIT_EN
- Defined:
  - Adds input cfg_sweeps [7:0] (captured with the config) and output done (1-cycle pulse).
  - A sweep counter increments on each bound_hit.
  - When it reaches cfg_sweeps (nonzero): done pulses on that edge, state -> IDLE, count held.
  - cfg_sweeps=0 means unlimited.
  - Sweep counter clears on config accept and on reset.
- Undefined: neither port exists; RUN continues until stop or reset.

Test Plan:
- Reset, then cfg lo=3 hi=6 mode=00 dwell=0, start -> count 3,4,5,6,3,4 on consecutive cycles; bound_hit on the 6 and the 3.
- cfg lo=0 hi=15 mode=10 dwell=2, start -> count steps every 3 cycles 0..15,14,...,0,1; dir flips on the step to 14 and on the step to 1.
- cfg lo=9 hi=4 -> cfg_err single pulse, cfg_ready stays 1, count unchanged, start ignored.
- RUN mode 01 lo=2 hi=5; pause high 5 cycles mid-dwell -> count frozen, then resumes with remaining dwell; pause+stop same cycle -> IDLE.
- RST low during RUN at count=7 -> next cycle count=0, dir=0, busy=0, cfg_ready=1; cfg_valid during RUN ignored.
- With UPDOWN_SWEEP_LIMIT_EN, lo=0 hi=3 mode=10 dwell=0 sweeps=2 -> done pulses on the step reaching 0 after 3; then IDLE with count=0.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Configurable up/down sweep sequencer: steps a WIDTH-bit count between bounds under start/pause/stop.
// Optional macro UPDOWN_SWEEP_LIMIT_EN adds cfg_sweeps/done to end the sweep after N bound hits.
module updown_sweep_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               Clk,
    input  logic               RST,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_lo,
    input  logic [WIDTH-1:0]   cfg_hi,
    input  logic [1:0]         cfg_mode,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic               cfg_err,
    input  logic               start,
    input  logic               pause,
    input  logic               stop,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
`ifdef UPDOWN_SWEEP_LIMIT_EN
    input  logic [7:0]         cfg_sweeps,
    output logic               done,
`endif
    output logic               bound_hit
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [1:0]         r_mode;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_timer;
    logic [WIDTH-1:0]   r_count;
    logic               r_dir;
    logic               r_busy;
    logic               r_cfg_ready;
    logic               r_cfg_err;
    logic               r_bound_hit;

    logic [WIDTH-1:0]   w_next_count;
    logic               w_next_dir;
    logic               w_next_hit;
    logic               w_limit_reached;

`ifdef UPDOWN_SWEEP_LIMIT_EN
    logic [7:0]         r_sweeps;
    logic [7:0]         r_sweep_cnt;
    logic               r_done;
    logic [7:0]         w_sweep_inc;

    assign w_sweep_inc     = r_sweep_cnt + 8'(1);
    assign w_limit_reached = w_next_hit && (r_sweeps != 8'd0) && (w_sweep_inc == r_sweeps);
    assign done            = r_done;
`else
    assign w_limit_reached = 1'b0;
`endif

    assign count     = r_count;
    assign dir       = r_dir;
    assign busy      = r_busy;
    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign bound_hit = r_bound_hit;

    // Value and direction the count takes on its next step.
    always_comb begin
        w_next_count = r_count;
        w_next_dir   = r_dir;
        case (r_mode)
            2'b00: w_next_count = (r_count == r_hi) ? r_lo : r_count + WIDTH'(1);
            2'b01: w_next_count = (r_count == r_lo) ? r_hi : r_count - WIDTH'(1);
            default: begin
                if (r_lo == r_hi) begin
                    w_next_dir = ~r_dir;
                end else if (!r_dir) begin
                    if (r_count == r_hi) begin
                        w_next_dir   = 1'b1;
                        w_next_count = r_hi - WIDTH'(1);
                    end else begin
                        w_next_count = r_count + WIDTH'(1);
                    end
                end else begin
                    if (r_count == r_lo) begin
                        w_next_dir   = 1'b0;
                        w_next_count = r_lo + WIDTH'(1);
                    end else begin
                        w_next_count = r_count - WIDTH'(1);
                    end
                end
            end
        endcase
    end

    assign w_next_hit = (w_next_count == r_lo) || (w_next_count == r_hi);

    // Sequencer state, stored configuration and all registered outputs.
    always_ff @(posedge Clk) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_lo        <= '0;
            r_hi        <= '1;
            r_mode      <= 2'b00;
            r_dwell     <= '0;
            r_timer     <= '0;
            r_count     <= '0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
            r_bound_hit <= 1'b0;
`ifdef UPDOWN_SWEEP_LIMIT_EN
            r_sweeps    <= 8'd0;
            r_sweep_cnt <= 8'd0;
            r_done      <= 1'b0;
`endif
        end else begin
            r_cfg_err   <= 1'b0;
            r_bound_hit <= 1'b0;
`ifdef UPDOWN_SWEEP_LIMIT_EN
            r_done      <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_lo <= cfg_hi) begin
                            r_lo        <= cfg_lo;
                            r_hi        <= cfg_hi;
                            r_mode      <= cfg_mode;
                            r_dwell     <= cfg_dwell;
                            r_count     <= cfg_mode[0] ? cfg_hi : cfg_lo;
                            r_dir       <= cfg_mode[0];
                            r_state     <= S_ARMED;
                            r_busy      <= 1'b1;
                            r_cfg_ready <= 1'b0;
`ifdef UPDOWN_SWEEP_LIMIT_EN
                            r_sweeps    <= cfg_sweeps;
                            r_sweep_cnt <= 8'd0;
`endif
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (stop) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else if (!pause && start) begin
                        r_state <= S_RUN;
                        r_timer <= '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else if (pause) begin
                        r_state <= S_HOLD;
                    end else if (r_timer == r_dwell) begin
                        r_timer     <= '0;
                        r_count     <= w_next_count;
                        r_dir       <= w_next_dir;
                        r_bound_hit <= w_next_hit;
`ifdef UPDOWN_SWEEP_LIMIT_EN
                        if (w_next_hit) begin
                            r_sweep_cnt <= w_sweep_inc;
                        end
                        r_done <= w_limit_reached;
`endif
                        if (w_limit_reached) begin
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_cfg_ready <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + DWELL_W'(1);
                    end
                end
                S_HOLD: begin
                    if (stop) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else if (!pause) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed self-checking bench for updown_sweep_ctrl; define UPDOWN_SWEEP_LIMIT_EN to also cover the sweep limit.
module tb_updown_sweep_ctrl;

    logic       Clk;
    logic       RST;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_lo;
    logic [3:0] cfg_hi;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_dwell;
    logic       cfg_err;
    logic       start;
    logic       pause;
    logic       stop;
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic       bound_hit;
`ifdef UPDOWN_SWEEP_LIMIT_EN
    logic [7:0] cfg_sweeps;
    logic       done;
`endif

    int n_checks;
    int n_fail;
    int e_cnt;
    int e_dir;
    int exp1_cnt [5] = '{4, 5, 6, 3, 4};
    int exp1_bh  [5] = '{0, 0, 1, 1, 0};

    updown_sweep_ctrl #(.WIDTH(4), .DWELL_W(8)) u_dut (
        .Clk       (Clk),
        .RST       (RST),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_lo    (cfg_lo),
        .cfg_hi    (cfg_hi),
        .cfg_mode  (cfg_mode),
        .cfg_dwell (cfg_dwell),
        .cfg_err   (cfg_err),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .count     (count),
        .dir       (dir),
        .busy      (busy),
`ifdef UPDOWN_SWEEP_LIMIT_EN
        .cfg_sweeps(cfg_sweeps),
        .done      (done),
`endif
        .bound_hit (bound_hit)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_cfg(input logic [3:0] lo, input logic [3:0] hi,
                            input logic [1:0] mode, input logic [7:0] dwell);
        cfg_lo    = lo;
        cfg_hi    = hi;
        cfg_mode  = mode;
        cfg_dwell = dwell;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        RST       = 1'b0;
        cfg_valid = 1'b0;
        cfg_lo    = 4'd0;
        cfg_hi    = 4'd0;
        cfg_mode  = 2'b00;
        cfg_dwell = 8'd0;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
`ifdef UPDOWN_SWEEP_LIMIT_EN
        cfg_sweeps = 8'd0;
`endif
        tick();
        tick();
        check("rst_count", 32'(count), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_bh", 32'(bound_hit), 0);
        RST = 1'b1;

        // up-wrap 3..6, one step per cycle
        send_cfg(4'd3, 4'd6, 2'b00, 8'd0);
        check("t1_busy", 32'(busy), 1);
        check("t1_ready", 32'(cfg_ready), 0);
        check("t1_armed_cnt", 32'(count), 3);
        do_start();
        check("t1_run_cnt", 32'(count), 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_cnt", 32'(count), 32'(exp1_cnt[i]));
            check("t1_bh", 32'(bound_hit), 32'(exp1_bh[i]));
        end
        do_stop();
        check("t1_stop_busy", 32'(busy), 0);
        check("t1_stop_ready", 32'(cfg_ready), 1);
        check("t1_stop_cnt", 32'(count), 4);

        // rejected config: lo > hi
        send_cfg(4'd9, 4'd4, 2'b00, 8'd0);
        check("t3_err", 32'(cfg_err), 1);
        check("t3_ready", 32'(cfg_ready), 1);
        check("t3_cnt", 32'(count), 4);
        tick();
        check("t3_err_pulse", 32'(cfg_err), 0);
        do_start();
        check("t3_start_busy", 32'(busy), 0);
        check("t3_start_cnt", 32'(count), 4);

        // bounce 0..15 starting up, dwell 2
        send_cfg(4'd0, 4'd15, 2'b10, 8'd2);
        check("t2_armed_cnt", 32'(count), 0);
        do_start();
        e_cnt = 0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            check("t2_dwell_a", 32'(count), 32'(e_cnt));
            tick();
            check("t2_dwell_b", 32'(count), 32'(e_cnt));
            tick();
            if (k <= 15) begin
                e_cnt = k;
                e_dir = 0;
            end else if (k <= 30) begin
                e_cnt = 30 - k;
                e_dir = 1;
            end else begin
                e_cnt = 1;
                e_dir = 0;
            end
            check("t2_cnt", 32'(count), 32'(e_cnt));
            check("t2_dir", 32'(dir), 32'(e_dir));
            check("t2_bh", 32'(bound_hit), (e_cnt == 0 || e_cnt == 15) ? 32'd1 : 32'd0);
        end
        do_stop();

        // down-wrap 2..5, dwell 3, pause mid-dwell
        send_cfg(4'd2, 4'd5, 2'b01, 8'd3);
        check("t4_armed_cnt", 32'(count), 5);
        check("t4_armed_dir", 32'(dir), 1);
        do_start();
        for (int i = 0; i < 3; i++) tick();
        check("t4_pre_step", 32'(count), 5);
        tick();
        check("t4_step1", 32'(count), 4);
        tick();
        tick();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_cnt", 32'(count), 4);
            check("t4_hold_busy", 32'(busy), 1);
        end
        pause = 1'b0;
        tick();
        check("t4_resume_a", 32'(count), 4);
        tick();
        check("t4_resume_b", 32'(count), 4);
        tick();
        check("t4_resume_step", 32'(count), 3);
        for (int i = 0; i < 4; i++) tick();
        check("t4_lo_cnt", 32'(count), 2);
        check("t4_lo_bh", 32'(bound_hit), 1);
        pause = 1'b1;
        stop  = 1'b1;
        tick();
        pause = 1'b0;
        stop  = 1'b0;
        check("t4_ps_busy", 32'(busy), 0);
        check("t4_ps_ready", 32'(cfg_ready), 1);
        check("t4_ps_cnt", 32'(count), 2);
        check("t4_ps_dir", 32'(dir), 1);

        // reset mid-run; cfg_valid while running is ignored
        send_cfg(4'd0, 4'd15, 2'b00, 8'd0);
        do_start();
        cfg_lo    = 4'd9;
        cfg_hi    = 4'd4;
        cfg_valid = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("t5_cnt", 32'(count), 32'(i));
            check("t5_no_err", 32'(cfg_err), 0);
            check("t5_ready", 32'(cfg_ready), 0);
        end
        cfg_valid = 1'b0;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("t5_rst_cnt", 32'(count), 0);
        check("t5_rst_dir", 32'(dir), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_ready", 32'(cfg_ready), 1);

`ifdef UPDOWN_SWEEP_LIMIT_EN
        // bounce 0..3, stop after two bound hits
        cfg_sweeps = 8'd2;
        send_cfg(4'd0, 4'd3, 2'b10, 8'd0);
        cfg_sweeps = 8'd0;
        do_start();
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t6_done", 32'(done), (i == 6) ? 32'd1 : 32'd0);
        end
        check("t6_cnt", 32'(count), 0);
        check("t6_busy", 32'(busy), 0);
        tick();
        check("t6_done_pulse", 32'(done), 0);
        check("t6_idle_cnt", 32'(count), 0);
        check("t6_ready", 32'(cfg_ready), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
